pipe_scoreboard: RTL and testbench



---
 rtl/pipe_scoreboard_if.sv | 37 +++
 rtl/pipe_scoreboard.sv | 112 +++++++++++
 tb/tb_pipe_scoreboard.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_scoreboard_if.sv
// pipe_scoreboard_if: decode/writeback/flush handshake bundle for pipe_scoreboard.
//   issue_*      decode-side instruction descriptor and its ready/stall answer
//   wb_*         one retiring write per cycle from writeback
//   kill_*       one killed in-flight write per cycle from flush
// Modports: master = pipeline side (drives issue/wb/kill), slave = scoreboard.
interface pipe_scoreboard_if #(
    parameter int unsigned REG_AW = 5
);
    logic              issue_valid;
    logic [REG_AW-1:0] issue_rs1;
    logic              issue_rs1_use;
    logic [REG_AW-1:0] issue_rs2;
    logic              issue_rs2_use;
    logic [REG_AW-1:0] issue_rd;
    logic              issue_rd_wr;
    logic              issue_long;
    logic              issue_ready;
    logic              stall;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic              kill_valid;
    logic [REG_AW-1:0] kill_rd;

    modport master (
        output issue_valid, issue_rs1, issue_rs1_use, issue_rs2, issue_rs2_use,
        output issue_rd, issue_rd_wr, issue_long,
        output wb_valid, wb_rd, kill_valid, kill_rd,
        input  issue_ready, stall
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs1_use, issue_rs2, issue_rs2_use,
        input  issue_rd, issue_rd_wr, issue_long,
        input  wb_valid, wb_rd, kill_valid, kill_rd,
        output issue_ready, stall
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: per-register in-flight write counter between decode and execute.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   sb           pipe_scoreboard_if.slave (issue / wb / kill handshake, issue_ready, stall)
//   busy_mask    registered, bit r set while register r has outstanding writes
//   err          sticky, set by a retire/kill to a register with no outstanding write
// Build option: define PIPE_SB_FWD_EN when execute forwards single-cycle results;
// readers then only block on multi-cycle producers. Default blocks on any pending write.
module pipe_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned MAX_PEND = 3,
    parameter int unsigned CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    pipe_scoreboard_if.slave    sb,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                err
);

    logic [NUM_REGS-1:0][CNT_W-1:0] count_q, count_d;
    logic [NUM_REGS-1:0]            long_q, long_d;
    logic [NUM_REGS-1:0]            busy_q, busy_d;
    logic                           err_q, err_d;

    // Per-register "blocks a reader" vector.
    logic [NUM_REGS-1:0] read_blk;
`ifdef PIPE_SB_FWD_EN
    assign read_blk = long_q;
`else
    assign read_blk = busy_q;
`endif

    logic rs1_blk, rs2_blk, rd_full, rd_long;
    logic fire;

    // Address decode by compare so out-of-range addresses simply never match.
    // Loops start at 1: x0 never blocks and is never tracked.
    always_comb begin
        rs1_blk = 1'b0;
        rs2_blk = 1'b0;
        rd_full = 1'b0;
        rd_long = 1'b0;
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            if (sb.issue_rs1 == REG_AW'(r)) rs1_blk = read_blk[r];
            if (sb.issue_rs2 == REG_AW'(r)) rs2_blk = read_blk[r];
            if (sb.issue_rd == REG_AW'(r)) begin
                rd_full = (count_q[r] == CNT_W'(MAX_PEND));
                rd_long = long_q[r];
            end
        end
    end

    assign sb.issue_ready = !(sb.issue_rs1_use && rs1_blk) &&
                            !(sb.issue_rs2_use && rs2_blk) &&
                            !(sb.issue_rd_wr && (rd_full || rd_long));
    assign sb.stall       = sb.issue_valid && !sb.issue_ready;
    assign fire           = sb.issue_valid && sb.issue_ready;

    logic             inc;
    logic [1:0]       dec;
    logic [CNT_W:0]   sum;

    always_comb begin
        count_d = count_q;
        long_d  = long_q;
        busy_d  = '0;
        err_d   = err_q;
        inc     = 1'b0;
        dec     = '0;
        sum     = '0;
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            inc = fire && sb.issue_rd_wr && (sb.issue_rd == REG_AW'(r));
            dec = {1'b0, sb.wb_valid && (sb.wb_rd == REG_AW'(r))} +
                  {1'b0, sb.kill_valid && (sb.kill_rd == REG_AW'(r))};
            sum = {1'b0, count_q[r]} + (CNT_W + 1)'(inc);
            if ((CNT_W + 1)'(dec) > sum) begin
                // Retire without a matching pending write: clamp and flag.
                count_d[r] = '0;
                err_d      = 1'b1;
            end else begin
                count_d[r] = CNT_W'(sum - (CNT_W + 1)'(dec));
            end
            // long tracks the youngest producer; it dies with the last pending write.
            if (inc) begin
                long_d[r] = sb.issue_long;
            end else if (count_d[r] == '0) begin
                long_d[r] = 1'b0;
            end
            busy_d[r] = (count_d[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            long_q  <= '0;
            busy_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            long_q  <= long_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign busy_mask = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_pipe_scoreboard.sv
module tb_pipe_scoreboard;

`ifdef PIPE_SB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int MAXP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] busy_mask;
    logic        err;

    always #5 clk = ~clk;

    pipe_scoreboard_if #(.REG_AW(5)) sb_if ();

    pipe_scoreboard #(
        .NUM_REGS(32),
        .REG_AW  (5),
        .MAX_PEND(3),
        .CNT_W   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sb       (sb_if.slave),
        .busy_mask(busy_mask),
        .err      (err)
    );

    typedef struct {
        bit v; logic [4:0] rs1; bit u1; logic [4:0] rs2; bit u2;
        logic [4:0] rd; bit wr; bit lg;
        bit wv; logic [4:0] wrd; bit kv; logic [4:0] krd;
        bit ready; logic [31:0] busy; bit err;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: outstanding-write count and long flag per register.
    int m_cnt[32];
    bit m_lng[32];
    bit m_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(bit v, logic [4:0] rs1, bit u1, logic [4:0] rs2, bit u2,
                                logic [4:0] rd, bit wr, bit lg, bit wv, logic [4:0] wrd,
                                bit kv, logic [4:0] krd, bit rdy, logic [31:0] busy, bit e);
        vec_t x;
        x.v = v; x.rs1 = rs1; x.u1 = u1; x.rs2 = rs2; x.u2 = u2;
        x.rd = rd; x.wr = wr; x.lg = lg; x.wv = wv; x.wrd = wrd; x.kv = kv; x.krd = krd;
        x.ready = rdy; x.busy = busy; x.err = e;
        return x;
    endfunction

    function automatic bit src_haz(bit use_s, logic [4:0] s);
        if (!use_s || s == 0) return 1'b0;
        return FWD ? m_lng[s] : (m_cnt[s] != 0);
    endfunction

    function automatic bit m_ready();
        logic [4:0] rd;
        rd = sb_if.issue_rd;
        if (src_haz(sb_if.issue_rs1_use, sb_if.issue_rs1)) return 1'b0;
        if (src_haz(sb_if.issue_rs2_use, sb_if.issue_rs2)) return 1'b0;
        if (sb_if.issue_rd_wr && rd != 0 && (m_cnt[rd] == MAXP || m_lng[rd])) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = '0;
        for (int r = 1; r < 32; r++) b[r] = (m_cnt[r] != 0);
        return b;
    endfunction

    task automatic m_reset();
        for (int r = 0; r < 32; r++) begin
            m_cnt[r] = 0;
            m_lng[r] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic m_update();
        bit fire;
        int inc, dec, n;
        fire = sb_if.issue_valid && m_ready();
        for (int r = 1; r < 32; r++) begin
            inc = (fire && sb_if.issue_rd_wr && sb_if.issue_rd == r) ? 1 : 0;
            dec = ((sb_if.wb_valid && sb_if.wb_rd == r) ? 1 : 0) +
                  ((sb_if.kill_valid && sb_if.kill_rd == r) ? 1 : 0);
            n = m_cnt[r] + inc - dec;
            if (n < 0) begin
                n = 0;
                m_err = 1'b1;
            end
            if (inc == 1) m_lng[r] = sb_if.issue_long;
            else if (n == 0) m_lng[r] = 1'b0;
            m_cnt[r] = n;
        end
    endtask

    task automatic drive(input vec_t x);
        sb_if.issue_valid   = x.v;
        sb_if.issue_rs1     = x.rs1;
        sb_if.issue_rs1_use = x.u1;
        sb_if.issue_rs2     = x.rs2;
        sb_if.issue_rs2_use = x.u2;
        sb_if.issue_rd      = x.rd;
        sb_if.issue_rd_wr   = x.wr;
        sb_if.issue_long    = x.lg;
        sb_if.wb_valid      = x.wv;
        sb_if.wb_rd         = x.wrd;
        sb_if.kill_valid    = x.kv;
        sb_if.kill_rd       = x.krd;
    endtask

    // One cycle: drive at negedge, check combinational ready, clock, check state.
    task automatic step(input string nm, input bit chk_tbl, input vec_t x);
        bit exp_rdy;
        @(negedge clk);
        drive(x);
        #1;
        exp_rdy = m_ready();
        check({nm, "_ready"}, 32'(sb_if.issue_ready), 32'(exp_rdy));
        check({nm, "_stall"}, 32'(sb_if.stall), 32'(x.v && !exp_rdy));
        if (chk_tbl) check({nm, "_ready_tbl"}, 32'(sb_if.issue_ready), 32'(x.ready));
        @(posedge clk);
        m_update();
        #1;
        check({nm, "_busy"}, busy_mask, m_busy());
        check({nm, "_err"}, 32'(err), 32'(m_err));
        if (chk_tbl) begin
            check({nm, "_busy_tbl"}, busy_mask, x.busy);
            check({nm, "_err_tbl"}, 32'(err), 32'(x.err));
        end
    endtask

    task automatic do_reset(input string nm);
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        drive(idle);
        @(posedge clk);
        m_reset();
        #1;
        check({nm, "_busy"}, busy_mask, 32'h0);
        check({nm, "_err"}, 32'(err), 32'h0);
        // Any source/dest combination must be ready on an empty scoreboard.
        sb_if.issue_rs1 = 5'($urandom_range(0, 31)); sb_if.issue_rs1_use = 1'b1;
        sb_if.issue_rs2 = 5'($urandom_range(0, 31)); sb_if.issue_rs2_use = 1'b1;
        sb_if.issue_rd  = 5'($urandom_range(0, 31)); sb_if.issue_rd_wr   = 1'b1;
        sb_if.issue_long = 1'b1;
        #1;
        check({nm, "_ready"}, 32'(sb_if.issue_ready), 32'h1);
        @(negedge clk);
        drive(idle);
        rst = 1'b0;
    endtask

    vec_t tbl[$];

    initial begin
        vec_t x;
        int r;
        // Directed sequence: each row is one cycle with expected ready/busy/err.
        tbl.push_back(mk(1,0,0,0,0, 5,1,0, 0,0,0,0, 1,     32'h20, 0)); // addi x5
        tbl.push_back(mk(1,5,1,0,0, 0,0,0, 0,0,0,0, FWD,   32'h20, 0)); // read x5
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 1,5,0,0, 1,     32'h00, 0)); // wb x5
        tbl.push_back(mk(1,5,1,0,0, 0,0,0, 0,0,0,0, 1,     32'h00, 0)); // read x5
        tbl.push_back(mk(1,0,0,0,0, 7,1,1, 0,0,0,0, 1,     32'h80, 0)); // mul x7
        tbl.push_back(mk(1,0,0,7,1, 0,0,0, 0,0,0,0, 0,     32'h80, 0)); // read x7
        tbl.push_back(mk(1,0,0,0,0, 7,1,0, 0,0,0,0, 0,     32'h80, 0)); // WAW x7
        tbl.push_back(mk(1,7,1,0,0, 0,0,0, 1,7,0,0, 0,     32'h00, 0)); // read + wb x7
        tbl.push_back(mk(1,7,1,0,0, 0,0,0, 0,0,0,0, 1,     32'h00, 0)); // read x7
        tbl.push_back(mk(1,0,0,0,0, 3,1,0, 0,0,0,0, 1,     32'h08, 0)); // x3 #1
        tbl.push_back(mk(1,0,0,0,0, 3,1,0, 0,0,0,0, 1,     32'h08, 0)); // x3 #2
        tbl.push_back(mk(1,0,0,0,0, 3,1,0, 0,0,0,0, 1,     32'h08, 0)); // x3 #3
        tbl.push_back(mk(1,0,0,0,0, 3,1,0, 0,0,0,0, 0,     32'h08, 0)); // x3 full
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 1,3,0,0, 1,     32'h08, 0)); // wb x3
        tbl.push_back(mk(1,0,0,0,0, 3,1,0, 0,0,0,0, 1,     32'h08, 0)); // x3 #4
        tbl.push_back(mk(1,0,0,0,0, 3,1,0, 0,0,0,0, 0,     32'h08, 0)); // full again
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 1,3,0,0, 1,     32'h08, 0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 1,3,0,0, 1,     32'h08, 0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 1,3,0,0, 1,     32'h00, 0)); // x3 drained
        tbl.push_back(mk(1,0,0,0,0, 4,1,0, 0,0,0,0, 1,     32'h10, 0)); // x4 cnt 1
        tbl.push_back(mk(1,0,0,0,0, 4,1,0, 1,4,0,0, 1,     32'h10, 0)); // issue+wb x4
        tbl.push_back(mk(1,0,0,0,0, 4,1,0, 0,0,0,0, 1,     32'h10, 0)); // x4 cnt 2
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 1,4,1,4, 1,     32'h00, 0)); // wb+kill x4
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 1,9,0,0, 1,     32'h00, 1)); // stray wb x9
        tbl.push_back(mk(0,0,0,0,0, 0,0,0, 0,0,0,0, 1,     32'h00, 1)); // err sticky
        tbl.push_back(mk(1,0,1,0,1, 0,1,1, 1,0,1,0, 1,     32'h00, 1)); // all on x0
        tbl.push_back(mk(1,0,0,0,0, 1,1,0, 0,0,0,0, 1,     32'h02, 1)); // x1
        tbl.push_back(mk(1,0,0,0,0, 2,1,1, 0,0,0,0, 1,     32'h06, 1)); // x2 long

        m_reset();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        do_reset("reset0");

        foreach (tbl[i]) step($sformatf("tbl%0d", i), 1'b1, tbl[i]);

        // Reset with x1/x2 pending: everything discarded, later retire is stray.
        do_reset("reset_mid");
        step("stray_wb_x1", 1'b1, mk(0,0,0,0,0, 0,0,0, 1,1,0,0, 1, 32'h0, 1));
        step("stray_kill_x2", 1'b1, mk(0,0,0,0,0, 0,0,0, 0,0,1,2, 1, 32'h0, 1));
        do_reset("reset1");

        // Random traffic on x0..x7 against the model.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) do_reset("reset_rand");
            x = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 3) == 0), 0, 0, 0, 0, 0, 0, 0);
            r = $urandom_range(0, 7);
            x.wrd = 5'(r);
            x.wv  = (m_cnt[r] > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 24) == 0);
            r = $urandom_range(0, 7);
            x.krd = 5'(r);
            x.kv  = (m_cnt[r] > 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
            step($sformatf("rand%0d", c), 1'b0, x);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
